// File: rtl/rtc_pkg.sv
// rtl/rtc_pkg.sv - shared RTC bus constants, state encoding and address tables
//
// Purpose: shared between the bus sequencer and the datapath address decode.
//   Provides the default phase length, table sizes, FSM state encoding, the
//   sweep mode type and the address lookup helpers for sweep and init tables.
// Ports: none (package).

package rtc_pkg;

  localparam int T_PHASE_DEF = 4;
  localparam int N_SWEEP     = 9;
  localparam int N_INIT      = 4;

  // Consecutive encoding: the timed phases A_SETUP..D_HOLD advance by +1.
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_A_SETUP  = 3'd1;
  localparam logic [2:0] ST_A_STROBE = 3'd2;
  localparam logic [2:0] ST_A_HOLD   = 3'd3;
  localparam logic [2:0] ST_D_SETUP  = 3'd4;
  localparam logic [2:0] ST_D_STROBE = 3'd5;
  localparam logic [2:0] ST_D_HOLD   = 3'd6;
  localparam logic [2:0] ST_NEXT     = 3'd7;

  typedef enum logic [1:0] {
    MODE_INIT  = 2'd0,
    MODE_WRITE = 2'd1,
    MODE_READ  = 2'd2
  } mode_e;

  // Display registers visited by read and write sweeps.
  function automatic logic [7:0] sweep_addr(input logic [7:0] idx);
    logic [7:0] a;
    case (idx)
      8'd0:    a = 8'h21;
      8'd1:    a = 8'h22;
      8'd2:    a = 8'h23;
      8'd3:    a = 8'h24;
      8'd4:    a = 8'h25;
      8'd5:    a = 8'h26;
      8'd6:    a = 8'h41;
      8'd7:    a = 8'h42;
      8'd8:    a = 8'h43;
      default: a = 8'h00;
    endcase
    return a;
  endfunction

  // Init writes; 0x02 is visited twice because the datapath supplies a
  // different data value for it on the second pass.
  function automatic logic [7:0] init_addr(input logic [7:0] idx);
    logic [7:0] a;
    case (idx)
      8'd0:    a = 8'h02;
      8'd1:    a = 8'h00;
      8'd2:    a = 8'h01;
      8'd3:    a = 8'h02;
      default: a = 8'h00;
    endcase
    return a;
  endfunction

  function automatic logic [7:0] entry_addr(input mode_e mode, input logic [7:0] idx);
    return (mode == MODE_INIT) ? init_addr(idx) : sweep_addr(idx);
  endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// rtl/rtc_phase_timer.sv - loadable down-counter timing one bus phase
//
// Purpose: counts the cycles of a bus phase. load has priority over dec;
//   the counter saturates at zero.
// Ports:
//   CLK, RST        clock, asynchronous active-high reset
//   load, load_val  load the counter with load_val
//   dec             decrement by one (ignored at zero)
//   cnt             current count
//   zero            count is zero (last cycle of the phase)

module rtc_phase_timer (
  input  logic       CLK,
  input  logic       RST,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       dec,
  output logic [7:0] cnt,
  output logic       zero
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != 8'd0)) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == 8'd0);

endmodule

// File: rtl/rtc_bus_sequencer.sv
// rtl/rtc_bus_sequencer.sv - RTC multiplexed-bus transaction sequencer
//
// Purpose: runs an init write sequence after reset, then read sweeps (RD_TICK)
//   and write sweeps (WR_REQ) over the display register table. Each
//   transaction is address phase (setup/strobe/hold), data phase
//   (setup/strobe/hold) and a one-cycle NEXT, each timed phase T_PHASE cycles.
// Ports:
//   CLK, RST                      clock, asynchronous active-high reset
//   RD_TICK, WR_REQ               one-cycle sweep requests (latched, sticky)
//   ADRESS                        register address of current transaction
//   BEnv_Adress, BEnv_Data        datapath bus drive enables (address / data)
//   BRes_Data                     datapath captures bus data for ADRESS
//   RTC_CS_n, RTC_RD_n, RTC_WR_n  RTC strobes, active low
//   RTC_AD                        0 address phase, 1 data phase / idle
//   BUSY                          sequence running or pending
//   DONE                          one-cycle pulse at end of a sequence

module rtc_bus_sequencer
  import rtc_pkg::*;
#(
  parameter int T_PHASE = T_PHASE_DEF,
  parameter int N_READ  = N_SWEEP
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RD_TICK,
  input  logic       WR_REQ,
  output logic [7:0] ADRESS,
  output logic       BEnv_Adress,
  output logic       BEnv_Data,
  output logic       BRes_Data,
  output logic       RTC_CS_n,
  output logic       RTC_RD_n,
  output logic       RTC_WR_n,
  output logic       RTC_AD,
  output logic       BUSY,
  output logic       DONE
);

  localparam logic [7:0] PH_LOAD   = 8'(T_PHASE - 1);
  localparam logic [7:0] LAST_READ = 8'(N_READ - 1);
  localparam logic [7:0] LAST_INIT = 8'(N_INIT - 1);

  logic [2:0] state_q, state_d;
  mode_e      mode_q, mode_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] adr_q, adr_d;
  logic       init_q, init_d;
  logic       wr_pend_q, wr_pend_d;
  logic       rd_pend_q, rd_pend_d;

  logic       tmr_load;
  logic       tmr_dec;
  logic [7:0] tmr_cnt;
  logic       tmr_zero;
  logic       last_entry;

  rtc_phase_timer u_timer (
    .CLK      (CLK),
    .RST      (RST),
    .load     (tmr_load),
    .load_val (PH_LOAD),
    .dec      (tmr_dec),
    .cnt      (tmr_cnt),
    .zero     (tmr_zero)
  );

  assign last_entry = (mode_q == MODE_INIT) ? (idx_q == LAST_INIT)
                                            : (idx_q == LAST_READ);

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    idx_d     = idx_q;
    adr_d     = adr_q;
    init_d    = init_q;
    wr_pend_d = wr_pend_q | WR_REQ;
    rd_pend_d = rd_pend_q | RD_TICK;
    tmr_load  = 1'b0;
    tmr_dec   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Init first, then write ahead of read. A request arriving in the
        // very cycle its pending bit clears is kept rather than lost.
        if (init_q || wr_pend_q || rd_pend_q) begin
          state_d  = ST_A_SETUP;
          tmr_load = 1'b1;
          idx_d    = 8'd0;
          if (init_q) begin
            mode_d = MODE_INIT;
            init_d = 1'b0;
          end else if (wr_pend_q) begin
            mode_d    = MODE_WRITE;
            wr_pend_d = WR_REQ;
          end else begin
            mode_d    = MODE_READ;
            rd_pend_d = RD_TICK;
          end
          adr_d = entry_addr(mode_d, 8'd0);
        end
      end

      ST_NEXT: begin
        if (last_entry) begin
          state_d = ST_IDLE;
        end else begin
          state_d  = ST_A_SETUP;
          tmr_load = 1'b1;
          idx_d    = idx_q + 8'd1;
          adr_d    = entry_addr(mode_q, idx_d);
        end
      end

      default: begin
        // Timed phases advance in encoding order; D_HOLD falls into NEXT,
        // which is untimed and so does not reload the timer.
        if (tmr_zero) begin
          state_d  = state_q + 3'd1;
          tmr_load = (state_q != ST_D_HOLD);
        end else begin
          tmr_dec = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_INIT;
      idx_q     <= 8'd0;
      adr_q     <= 8'h00;
      init_q    <= 1'b1;
      wr_pend_q <= 1'b0;
      rd_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      idx_q     <= idx_d;
      adr_q     <= adr_d;
      init_q    <= init_d;
      wr_pend_q <= wr_pend_d;
      rd_pend_q <= rd_pend_d;
    end
  end

  logic in_addr_ph;
  logic in_data_ph;
  logic is_write;
  logic d_hold_first;

  assign in_addr_ph   = (state_q >= ST_A_SETUP) && (state_q <= ST_A_HOLD);
  assign in_data_ph   = (state_q >= ST_D_SETUP) && (state_q <= ST_D_HOLD);
  assign is_write     = (mode_q != MODE_READ);
  assign d_hold_first = (state_q == ST_D_HOLD) && (tmr_cnt == PH_LOAD);

  // Outputs decode from registered state only, so the asynchronous reset
  // drops every enable and strobe in the same cycle it is asserted.
  assign ADRESS      = adr_q;
  assign BEnv_Adress = in_addr_ph;
  assign BEnv_Data   = in_data_ph && is_write;
  assign BRes_Data   = !is_write && (state_q == ST_D_STROBE);
  assign RTC_CS_n    = !(in_addr_ph || in_data_ph);
  assign RTC_AD      = !in_addr_ph;
  assign RTC_WR_n    = !((state_q == ST_A_STROBE) ||
                         (is_write && (state_q == ST_D_STROBE)));
  // Read strobe extends one cycle into D_HOLD to give the RTC data hold.
  assign RTC_RD_n    = !(!is_write && ((state_q == ST_D_STROBE) || d_hold_first));
  assign BUSY        = (state_q != ST_IDLE) || init_q || wr_pend_q || rd_pend_q;
  assign DONE        = (state_q == ST_NEXT) && last_entry;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// tb/tb_rtc_bus_sequencer.sv - directed self-checking bench for rtc_bus_sequencer

module tb_rtc_bus_sequencer;

  localparam int TP = 2;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       RD_TICK = 1'b0;
  logic       WR_REQ = 1'b0;
  logic [7:0] ADRESS;
  logic       BEnv_Adress, BEnv_Data, BRes_Data;
  logic       RTC_CS_n, RTC_RD_n, RTC_WR_n, RTC_AD;
  logic       BUSY, DONE;

  rtc_bus_sequencer #(.T_PHASE(TP), .N_READ(9)) dut (
    .CLK(CLK), .RST(RST), .RD_TICK(RD_TICK), .WR_REQ(WR_REQ),
    .ADRESS(ADRESS), .BEnv_Adress(BEnv_Adress), .BEnv_Data(BEnv_Data),
    .BRes_Data(BRes_Data), .RTC_CS_n(RTC_CS_n), .RTC_RD_n(RTC_RD_n),
    .RTC_WR_n(RTC_WR_n), .RTC_AD(RTC_AD), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [7:0] adr;
    logic [7:0] adlow;
    logic [7:0] benv_d;
    logic [7:0] bres;
    logic [7:0] rdn;
    logic [7:0] wrn;
  } tx_t;

  tx_t  tx_q[$];
  int   done_q[$];
  int   cyc = 0;
  int   viol = 0;
  bit   in_tx = 0;
  tx_t  cur;
  int   checks = 0;
  int   failures = 0;

  logic [7:0] sweep_tab [9] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};
  logic [7:0] init_tab  [4] = '{8'h02, 8'h00, 8'h01, 8'h02};
  localparam logic [16:0] RESET_OUT = {8'h00, 3'b000, 4'b1111, 2'b10};

  always @(posedge CLK) cyc <= cyc + 1;

  // Transaction recorder and continuous exclusion / address-stability monitor.
  always @(negedge CLK) begin
    if (RST) begin
      in_tx = 0;
    end else begin
      if (!RTC_CS_n) begin
        if (!in_tx) begin
          in_tx = 1;
          cur = '0;
          cur.adr = ADRESS;
        end else if (ADRESS !== cur.adr) begin
          viol++;
        end
        if (!RTC_AD)   cur.adlow++;
        if (BEnv_Data) cur.benv_d++;
        if (BRes_Data) cur.bres++;
        if (!RTC_RD_n) cur.rdn++;
        if (!RTC_WR_n) cur.wrn++;
      end else if (in_tx) begin
        if (ADRESS !== cur.adr) viol++;
        tx_q.push_back(cur);
        in_tx = 0;
      end
      if (BEnv_Adress && BEnv_Data) viol++;
      if (!RTC_RD_n && !RTC_WR_n) viol++;
      if (DONE) done_q.push_back(cyc);
    end
  end

  function automatic tx_t exp_tx(input bit wr, input logic [7:0] a);
    tx_t t;
    t.adr    = a;
    t.adlow  = 8'(3 * TP);
    t.benv_d = wr ? 8'(3 * TP) : 8'd0;
    t.bres   = wr ? 8'd0 : 8'(TP);
    t.rdn    = wr ? 8'd0 : 8'(TP + 1);
    t.wrn    = wr ? 8'(2 * TP) : 8'(TP);
    return t;
  endfunction

  task automatic clear_logs();
    tx_q.delete();
    done_q.delete();
    viol = 0;
  endtask

  task automatic wait_idle(input int limit, output int at_cyc, output bit ok);
    ok = 0;
    at_cyc = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge CLK);
      if (!BUSY) begin
        ok = 1;
        at_cyc = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    checks++;
    if ({ADRESS, BEnv_Adress, BEnv_Data, BRes_Data, RTC_CS_n, RTC_RD_n, RTC_WR_n,
         RTC_AD, BUSY, DONE} !== RESET_OUT) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=%h",
               {ADRESS, BEnv_Adress, BEnv_Data, BRes_Data, RTC_CS_n, RTC_RD_n,
                RTC_WR_n, RTC_AD, BUSY, DONE}, RESET_OUT);
    end
  endtask

  task automatic test_init(input string name);
    int t0, idle_at;
    bit ok;
    @(negedge CLK);
    clear_logs();
    RST = 1'b0;
    t0 = cyc;
    wait_idle(300, idle_at, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL %s_timeout busy still high", name); end
    checks++;
    if (done_q.size() != 1 || done_q[0] - t0 != 52) begin
      failures++;
      $display("FAIL %s_done pulses=%0d first_at=%0d want 1 pulse at 52", name,
               done_q.size(), (done_q.size() > 0) ? done_q[0] - t0 : -1);
    end
    checks++;
    if (idle_at - t0 != 53) begin
      failures++;
      $display("FAIL %s_busy_fall at=%0d want=53", name, idle_at - t0);
    end
    checks++;
    if (tx_q.size() != 4) begin
      failures++;
      $display("FAIL %s_tx_count got=%0d want=4", name, tx_q.size());
    end
    for (int i = 0; i < 4 && i < tx_q.size(); i++) begin
      checks++;
      if (tx_q[i] !== exp_tx(1'b1, init_tab[i])) begin
        failures++;
        $display("FAIL %s_tx%0d got=%h want=%h", name, i, tx_q[i], exp_tx(1'b1, init_tab[i]));
      end
    end
    checks++;
    if (viol != 0) begin failures++; $display("FAIL %s_monitor violations=%0d want=0", name, viol); end
  endtask

  task automatic test_read_sweep();
    int t0, idle_at;
    bit ok;
    @(negedge CLK);
    clear_logs();
    RD_TICK = 1'b1;
    t0 = cyc;
    @(negedge CLK);
    RD_TICK = 1'b0;
    wait_idle(400, idle_at, ok);
    checks++;
    if (!ok || done_q.size() != 1 || done_q[0] - t0 != 118 || idle_at - t0 != 119) begin
      failures++;
      $display("FAIL read_timing ok=%0d pulses=%0d done_at=%0d idle_at=%0d want 1 pulse at 118 idle 119",
               ok, done_q.size(), (done_q.size() > 0) ? done_q[0] - t0 : -1, idle_at - t0);
    end
    checks++;
    if (tx_q.size() != 9) begin failures++; $display("FAIL read_tx_count got=%0d want=9", tx_q.size()); end
    for (int i = 0; i < 9 && i < tx_q.size(); i++) begin
      checks++;
      if (tx_q[i] !== exp_tx(1'b0, sweep_tab[i])) begin
        failures++;
        $display("FAIL read_tx%0d got=%h want=%h", i, tx_q[i], exp_tx(1'b0, sweep_tab[i]));
      end
    end
    checks++;
    if (viol != 0) begin failures++; $display("FAIL read_monitor violations=%0d want=0", viol); end
  endtask

  task automatic test_write_and_read();
    int t0, idle_at;
    bit ok;
    @(negedge CLK);
    clear_logs();
    RD_TICK = 1'b1;
    WR_REQ  = 1'b1;
    t0 = cyc;
    @(negedge CLK);
    RD_TICK = 1'b0;
    WR_REQ  = 1'b0;
    wait_idle(600, idle_at, ok);
    checks++;
    if (!ok || done_q.size() != 2 || done_q[0] - t0 != 118 || done_q[1] - t0 != 236) begin
      failures++;
      $display("FAIL both_timing ok=%0d pulses=%0d first=%0d second=%0d want 2 pulses at 118 and 236",
               ok, done_q.size(), (done_q.size() > 0) ? done_q[0] - t0 : -1,
               (done_q.size() > 1) ? done_q[1] - t0 : -1);
    end
    checks++;
    if (tx_q.size() != 18) begin failures++; $display("FAIL both_tx_count got=%0d want=18", tx_q.size()); end
    for (int i = 0; i < 18 && i < tx_q.size(); i++) begin
      checks++;
      if (tx_q[i] !== exp_tx(i < 9, sweep_tab[i % 9])) begin
        failures++;
        $display("FAIL both_tx%0d got=%h want=%h", i, tx_q[i], exp_tx(i < 9, sweep_tab[i % 9]));
      end
    end
    checks++;
    if (viol != 0) begin failures++; $display("FAIL both_monitor violations=%0d want=0", viol); end
  endtask

  task automatic test_repeat_absorb();
    int idle_at;
    bit ok;
    @(negedge CLK);
    clear_logs();
    RD_TICK = 1'b1;
    @(negedge CLK);
    RD_TICK = 1'b0;
    for (int p = 0; p < 3; p++) begin
      repeat (20 + 10 * p) @(negedge CLK);
      RD_TICK = 1'b1;
      @(negedge CLK);
      RD_TICK = 1'b0;
    end
    wait_idle(600, idle_at, ok);
    repeat (50) @(negedge CLK);
    checks++;
    if (!ok || done_q.size() != 2 || (done_q.size() == 2 && done_q[1] - done_q[0] != 118)) begin
      failures++;
      $display("FAIL repeat_sweeps ok=%0d pulses=%0d want 2 pulses 118 apart", ok, done_q.size());
    end
    checks++;
    if (tx_q.size() != 18 || BUSY !== 1'b0) begin
      failures++;
      $display("FAIL repeat_no_extra tx=%0d busy=%b want tx=18 busy=0", tx_q.size(), BUSY);
    end
    for (int i = 0; i < 18 && i < tx_q.size(); i++) begin
      checks++;
      if (tx_q[i] !== exp_tx(1'b0, sweep_tab[i % 9])) begin
        failures++;
        $display("FAIL repeat_tx%0d got=%h want=%h", i, tx_q[i], exp_tx(1'b0, sweep_tab[i % 9]));
      end
    end
    checks++;
    if (viol != 0) begin failures++; $display("FAIL repeat_monitor violations=%0d want=0", viol); end
  endtask

  task automatic test_reset_mid();
    bit found;
    found = 0;
    @(negedge CLK);
    RD_TICK = 1'b1;
    @(negedge CLK);
    RD_TICK = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK);
      if (ADRESS == 8'h24 && BRes_Data && !RTC_RD_n) begin
        found = 1;
        break;
      end
    end
    checks++;
    if (!found) begin failures++; $display("FAIL midreset_reach d_strobe of 0x24 not seen"); end
    #2 RST = 1'b1;
    #1;
    checks++;
    if ({ADRESS, BEnv_Adress, BEnv_Data, BRes_Data, RTC_CS_n, RTC_RD_n, RTC_WR_n,
         RTC_AD, BUSY, DONE} !== RESET_OUT) begin
      failures++;
      $display("FAIL midreset_outputs got=%h want=%h",
               {ADRESS, BEnv_Adress, BEnv_Data, BRes_Data, RTC_CS_n, RTC_RD_n,
                RTC_WR_n, RTC_AD, BUSY, DONE}, RESET_OUT);
    end
    @(negedge CLK);
    test_init("reinit");
  endtask

  initial begin
    test_reset();
    test_init("init");
    test_read_sweep();
    test_write_and_read();
    test_repeat_absorb();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
